md_seq_ctrl: RTL and testbench

- Iterative multiply/divide sequencer for the MIPS datapath; owns the HI/LO registers.
- Executes MULTU/DIVU (and MULT/DIV when enabled) over 32 iteration cycles with a shift-add multiplier and a restoring divider.
- Exposes busy so the pipeline control can stall MFHI/MFLO and further multiply/divide issue.
- Also services MTHI/MTLO writes.

---
 rtl/md_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_md_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: iterative multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiplier and restoring divider, one iteration per clock over
// ITER cycles, plus MTHI/MTLO writes while idle.
// Optional feature macro: SIGNED_MD_EN (op[1]=1 selects signed MULT/DIV).
module md_seq_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  // acc_hi holds P_hi (multiply) or the remainder R (divide); acc_lo holds P_lo or Q.
  // R never exceeds 32 bits after an iteration, so 32 bits of storage suffice.
  logic [31:0]     acc_hi_q, acc_hi_d;
  logic [31:0]     acc_lo_q, acc_lo_d;
  // Multiplicand (multiply) or divisor (divide), as a magnitude.
  logic [31:0]     opnd_q, opnd_d;

  logic [31:0] a_mag, b_mag;
  logic [31:0] res_hi, res_lo;
  logic        last_iter;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;

  assign last_iter = (count_q == CntW'(ITER - 1));

`ifdef SIGNED_MD_EN
  logic        neg_a_q, neg_b_q, is_div_q;
  logic        sgn_op;
  logic [63:0] prod_raw, prod_fix;

  assign sgn_op = op[1];
  assign a_mag  = (sgn_op && a[31]) ? (~a + 32'd1) : a;
  assign b_mag  = (sgn_op && b[31]) ? (~b + 32'd1) : b;

  // Latch operand signs and operation kind at launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      neg_a_q  <= sgn_op & a[31];
      neg_b_q  <= sgn_op & b[31];
      is_div_q <= op[0];
    end
  end

  // Apply the sign fix to the unsigned core result.
  always_comb begin
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw + 64'd1) : prod_raw;
    if (is_div_q) begin
      res_lo = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 32'd1) : acc_lo_q;
      res_hi = neg_a_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
    end else begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign res_hi = acc_hi_q;
  assign res_lo = acc_lo_q;
`endif

  // One multiply step and one divide step, computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
  end

  // Sequencer next-state: launch, iterate, write back, and MT writes while idle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over a simultaneous MT write
          state_d  = op[0] ? StDiv : StMul;
          count_d  = '0;
          busy_d   = 1'b1;
          opnd_d   = op[0] ? b_mag : a_mag;
          acc_hi_d = 32'd0;
          acc_lo_d = op[0] ? a_mag : b_mag;
        end else begin
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
        end
      end
      StMul: begin
        acc_hi_d = mul_sum[32:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        count_d  = count_q + 1'b1;
        if (last_iter) state_d = StFin;
      end
      StDiv: begin
        // Non-negative trial (bit 32 clear) restores nothing and sets the quotient bit.
        if (!div_trial[32]) begin
          acc_hi_d = div_trial[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (last_iter) state_d = StFin;
      end
      StFin: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opnd_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl; randomized ops checked against an
// arithmetic reference model. Honors SIGNED_MD_EN the same way as the design.
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, we_hi, we_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  md_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic from the operation's definition.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el);
    logic        sgn;
    logic [63:0] p;
    longint      sx, sy, q, r;
    sgn = 1'b0;
`ifdef SIGNED_MD_EN
    sgn = o[1];
`endif
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    if (!o[0]) begin
      p  = 64'(sx * sy);
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'd0) begin
      // quotient of all ones on the magnitude, remainder is the dividend
      el = (sgn && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
      eh = x;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end
  endtask

  // Launch one op from idle and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcyc, output logic [31:0] rh,
                        output logic [31:0] rl, output logic done_after);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    lat  = 1;
    bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      tick();
      lat++;
    end
    rh = hi;
    rl = lo;
    tick();
    done_after = done;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_multu_max();
    int lat, bc; logic [31:0] rh, rl; logic da;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, rh, rl, da);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    checks++;
    if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", rh, rl);
    end
    checks++;
    if (da !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL multu_done_pulse: got done=%b busy=%b want 0 0", da, busy);
    end
  endtask

  task automatic test_divu();
    int lat, bc; logic [31:0] rh, rl; logic da;
    run_op(2'b01, 32'd100, 32'd7, lat, bc, rh, rl, da);
    checks++;
    if (rl !== 32'd14 || rh !== 32'd2) begin
      errors++; $display("FAIL divu_100_7: got hi=%0d lo=%0d want hi=2 lo=14", rh, rl);
    end
    run_op(2'b01, 32'd5, 32'd0, lat, bc, rh, rl, da);
    checks++;
    if (rl !== 32'hFFFF_FFFF || rh !== 32'd5) begin
      errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h want 5 ffffffff", rh, rl);
    end
    checks++;
    if (lat !== 34 || bc !== 33) begin
      errors++; $display("FAIL divu_zero_latency: got lat=%0d busy=%0d want 34 33", lat, bc);
    end
  endtask

  task automatic test_mt_write();
    we_hi = 1'b1; wd = 32'h0000_1234;
    tick();
    we_hi = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mthi: got hi=%h lo=%h want 00001234 ffffffff", hi, lo);
    end
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hCAFE_F00D;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL mt_both: got hi=%h lo=%h want cafef00d", hi, lo);
    end
    // start together with MT write: write dropped
    start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1; we_hi = 1'b1; wd = 32'h77;
    tick();
    start = 1'b0; we_hi = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || busy !== 1'b1) begin
      errors++; $display("FAIL start_beats_mt: got hi=%h busy=%b want cafef00d 1", hi, busy);
    end
    for (int i = 0; i < 40 && busy; i++) tick();
    tick();
  endtask

  task automatic test_busy_ignore();
    int dones; logic held;
    we_hi = 1'b1; wd = 32'h0000_1234;
    tick();
    we_hi = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    dones = 0; held = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd2; we_lo = 1'b1; wd = 32'hDEAD;
      end else begin
        start = 1'b0; we_lo = 1'b0;
      end
      if (busy && hi !== 32'h0000_1234) held = 1'b0;
      if (done) dones++;
      tick();
    end
    start = 1'b0; we_lo = 1'b0;
    checks++;
    if (!held) begin errors++; $display("FAIL hi_held_while_busy: got changed want 00001234"); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", dones); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++; $display("FAIL busy_ignore_result: got hi=%h lo=%h want 0 0000000c", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones; logic [31:0] rh, rl; logic da;
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hAAAA_5555;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active want 0", dones); end
    run_op(2'b00, 32'd6, 32'd7, lat, bc, rh, rl, da);
    checks++;
    if (rl !== 32'd42 || rh !== 32'd0) begin
      errors++; $display("FAIL after_abort: got hi=%0d lo=%0d want 0 42", rh, rl);
    end
  endtask

  task automatic test_signed();
    int lat, bc; logic [31:0] rh, rl; logic da;
`ifdef SIGNED_MD_EN
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat, bc, rh, rl, da);
    checks++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", rh, rl);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc, rh, rl, da);
    checks++;
    if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", rh, rl);
    end
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, rh, rl, da);
    checks++;
    if (rl !== 32'h8000_0000 || rh !== 32'd0) begin
      errors++; $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", rh, rl);
    end
`else
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat, bc, rh, rl, da);
    checks++;
    if (rh !== 32'h0000_0004 || rl !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL op10_unsigned: got %h_%h want 00000004_fffffff1", rh, rl);
    end
`endif
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL signed_latency: got %0d want 34", lat); end
  endtask

  task automatic test_random();
    int lat, bc; logic [31:0] rh, rl, eh, el, x, y; logic [1:0] o; logic da;
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 20));
        default: y = $urandom();
      endcase
      if (n % 5 == 4) x = 32'($urandom_range(0, 100));
      model(o, x, y, eh, el);
      run_op(o, x, y, lat, bc, rh, rl, da);
      checks++;
      if (rh !== eh || rl !== el) begin
        errors++;
        $display("FAIL random_op%0d: op=%b a=%h b=%h got %h_%h want %h_%h",
                 n, o, x, y, rh, rl, eh, el);
      end
      checks++;
      if (lat !== 34 || da !== 1'b0) begin
        errors++; $display("FAIL random_timing%0d: got lat=%0d done_after=%b want 34 0", n, lat, da);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0; wd = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_multu_max();
    test_divu();
    test_mt_write();
    test_busy_ignore();
    test_reset_abort();
    test_signed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
